// File: rtl/reg_file.sv
// Architectural integer register file: two combinational read ports, one debug
// read port and one synchronous write port, with x0 hard-wired to zero.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ra1,
    output logic [DATA_WIDTH-1:0] rd1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] dbg_ra,
    output logic [DATA_WIDTH-1:0] dbg_rd
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_active;

    assign wr_active = we && !rst && (wa != '0);

    // NOTE: the whole array is cleared on reset because stale contents must
    // never be observable afterwards; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking assignments keep same-edge readers seeing the old state.
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[wa] <= wd;
        end
    end

    // Write-first bypass: a read of the register being written returns wd.
    assign rd1    = (ra1 == '0)    ? '0 : (wr_active && wa == ra1)    ? wd : regs[ra1];
    assign rd2    = (ra2 == '0)    ? '0 : (wr_active && wa == ra2)    ? wd : regs[ra2];
    assign dbg_rd = (dbg_ra == '0) ? '0 : (wr_active && wa == dbg_ra) ? wd : regs[dbg_ra];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset clearing, x0 behaviour,
// write-first bypass, reset priority, debug port and back-to-back writes.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra1, ra2, wa, dbg_ra;
    logic [DW-1:0] rd1, rd2, wd, dbg_rd;
    logic          we;

    int checks = 0;
    int errors = 0;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ra1    (ra1),
        .rd1    (rd1),
        .ra2    (ra2),
        .rd2    (rd2),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        step();
        we = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; dbg_ra = '0;
        #2;

        // Random prior writes, then a single reset cycle with a colliding write.
        for (int i = 1; i < 32; i += 3) write_reg(AW'(i), $urandom);
        rst = 1'b1; we = 1'b1; wa = 5'd31; wd = 32'h8000_0001;
        step();
        rst = 1'b0; we = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            ra1 = AW'(i); ra2 = AW'(31 - i); dbg_ra = AW'(i);
            #1;
            check($sformatf("reset_rd1_%0d", i), rd1, '0);
            check($sformatf("reset_rd2_%0d", 31 - i), rd2, '0);
            check($sformatf("reset_dbg_%0d", i), dbg_rd, '0);
        end

        // Basic write, neighbours untouched.
        write_reg(5'd5, 32'hDEAD_BEEF);
        ra1 = 5'd5; ra2 = 5'd5; #1;
        check("wr5_rd1", rd1, 32'hDEAD_BEEF);
        check("wr5_rd2", rd2, 32'hDEAD_BEEF);
        ra1 = 5'd4; ra2 = 5'd6; #1;
        check("neigh4", rd1, '0);
        check("neigh6", rd2, '0);

        // Writes to x0 are ignored and never bypassed.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; dbg_ra = 5'd0; #1;
        check("x0_bypass_rd1", rd1, '0);
        check("x0_bypass_dbg", dbg_rd, '0);
        step();
        we = 1'b0; #1;
        check("x0_after", rd1, '0);

        // Write-first bypass on x7.
        write_reg(5'd7, 32'h1);
        we = 1'b1; wa = 5'd7; wd = 32'h2; ra2 = 5'd7; ra1 = 5'd7; #1;
        check("bypass_rd2_before", rd2, 32'h2);
        check("bypass_rd1_before", rd1, 32'h2);
        step();
        we = 1'b0; #1;
        check("bypass_rd2_after", rd2, 32'h2);
        wa = 5'd7; wd = 32'h99; #1;
        check("no_bypass_we0", rd2, 32'h2);
        step();
        check("no_write_we0", rd2, 32'h2);

        // Reset has priority over a same-cycle write; no bypass during reset.
        write_reg(5'd31, 32'h55);
        rst = 1'b1; we = 1'b1; wa = 5'd31; wd = 32'h8000_0001; ra1 = 5'd31; #1;
        check("rst_cycle_no_bypass", rd1, 32'h55);
        step();
        rst = 1'b0; we = 1'b0; #1;
        check("rst_drops_write31", rd1, '0);
        ra1 = 5'd5; ra2 = 5'd7; #1;
        check("rst_clears5", rd1, '0);
        check("rst_clears7", rd2, '0);

        // Debug port on the top register, including bypass.
        write_reg(5'd31, 32'h1234_5678);
        dbg_ra = 5'd31; #1;
        check("dbg_31", dbg_rd, 32'h1234_5678);
        we = 1'b1; wa = 5'd9; wd = 32'h0000_CAFE; dbg_ra = 5'd9; #1;
        check("dbg_bypass", dbg_rd, 32'h0000_CAFE);
        step();
        we = 1'b0; #1;
        check("dbg_9_stored", dbg_rd, 32'h0000_CAFE);

        // Back-to-back writes to x3.
        we = 1'b1; wa = 5'd3; wd = 32'hA;
        step();
        wd = 32'hB;
        step();
        we = 1'b0; ra1 = 5'd3; #1;
        check("b2b_x3", rd1, 32'hB);

        // Exact decode: x1 and x17 differ only in the top address bit.
        write_reg(5'd1, 32'h11);
        ra1 = 5'd1; ra2 = 5'd17; #1;
        check("alias_x1", rd1, 32'h11);
        check("alias_x17", rd2, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
